// File: rtl/mdio_frame_engine.sv
// Clause-22 MDIO master frame engine.
// Takes one management command per valid/ready handshake, serialises it onto
// MDC/MDIO (optional preamble, ST, OP, PHYAD, REGAD, TA, DATA) and returns read
// data plus a turnaround-error flag as a one-cycle response pulse.
module mdio_frame_engine #(
    parameter int CLK_DIV     = 10,   // ACLK cycles per MDC half-period, >= 2
    parameter bit PREAMBLE_EN = 1'b1  // 1 = send the 32-bit all-ones preamble
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        MDC,
    output logic        MDIO_O,
    output logic        MDIO_T,
    input  logic        MDIO_I
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic               mdc_reg, mdc_next;
    logic [5:0]         bit_cnt_reg, bit_cnt_next;
    logic               mdio_o_reg, mdio_o_next;
    logic               mdio_t_reg, mdio_t_next;
    logic               rd_reg, rd_next;
    // Everything after the preamble (ST..DATA) as one MSB-first shift register.
    logic [31:0]        tx_reg, tx_next;
    logic [15:0]        shift_reg, shift_next;
    logic               ta_err_reg, ta_err_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic [15:0]        rsp_rdata_reg, rsp_rdata_next;
    logic               rsp_err_reg, rsp_err_next;

    logic [5:0]         last_cnt;
    state_t             adv_state;
    state_t             bit_state;
    logic               last_bit;
    logic [31:0]        tx_load;
    logic [31:0]        tx_shifted;

    // Per-state bit count and successor state.
    always_comb begin
        last_cnt  = 6'd0;
        adv_state = ST_IDLE;
        case (state_reg)
            ST_PRE:  begin last_cnt = 6'd31; adv_state = ST_HDR;  end
            ST_HDR:  begin last_cnt = 6'd13; adv_state = ST_TA;   end
            ST_TA:   begin last_cnt = 6'd1;  adv_state = ST_DATA; end
            ST_DATA: begin last_cnt = 6'd15; adv_state = ST_DONE; end
            default: begin last_cnt = 6'd0;  adv_state = ST_IDLE; end
        endcase
    end

    // Next-state, bit sequencing, MDIO sampling and response generation.
    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        mdc_next       = mdc_reg;
        bit_cnt_next   = bit_cnt_reg;
        mdio_o_next    = mdio_o_reg;
        mdio_t_next    = mdio_t_reg;
        rd_next        = rd_reg;
        tx_next        = tx_reg;
        shift_next     = shift_reg;
        ta_err_next    = ta_err_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;

        // Read frames load TA/DATA as ones: the pad is released there anyway.
        tx_load = {2'b01, (cmd_read ? 2'b10 : 2'b01), cmd_phy_addr, cmd_reg_addr,
                   (cmd_read ? 2'b11 : 2'b10), (cmd_read ? 16'hFFFF : cmd_wdata)};
        // The preamble does not consume the shift register.
        tx_shifted = (state_reg == ST_PRE) ? tx_reg : {tx_reg[30:0], 1'b0};
        last_bit   = (bit_cnt_reg == last_cnt);
        bit_state  = last_bit ? adv_state : state_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                mdc_next    = 1'b0;
                mdio_o_next = 1'b1;
                mdio_t_next = 1'b1;
                state_next  = ST_IDLE;
                if (cmd_valid) begin
                    state_next   = PREAMBLE_EN ? ST_PRE : ST_HDR;
                    div_cnt_next = '0;
                    bit_cnt_next = 6'd0;
                    rd_next      = cmd_read;
                    tx_next      = tx_load;
                    ta_err_next  = 1'b0;
                    mdio_o_next  = PREAMBLE_EN ? 1'b1 : tx_load[31];
                    mdio_t_next  = 1'b0;
                end
            end
            default: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    if (!mdc_reg) begin
                        // MDC rising: the PHY's bit has had a full low phase to settle.
                        mdc_next = 1'b1;
                        if (state_reg == ST_TA && bit_cnt_reg == 6'd1)
                            ta_err_next = MDIO_I;
                        if (state_reg == ST_DATA)
                            shift_next = {shift_reg[14:0], MDIO_I};
                    end else begin
                        // MDC falling: end of bit, present the next one.
                        mdc_next = 1'b0;
                        tx_next  = tx_shifted;
                        if (last_bit) begin
                            bit_cnt_next = 6'd0;
                            state_next   = adv_state;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 6'd1;
                        end
                        if (last_bit && state_reg == ST_DATA) begin
                            mdio_o_next    = 1'b1;
                            mdio_t_next    = 1'b1;
                            rsp_valid_next = 1'b1;
                            if (rd_reg) begin
                                rsp_rdata_next = shift_reg;
                                rsp_err_next   = ta_err_reg;
                            end else begin
                                rsp_err_next   = 1'b0;
                            end
                        end else begin
                            mdio_o_next = (bit_state == ST_PRE) ? 1'b1 : tx_shifted[31];
                            mdio_t_next = rd_reg && (bit_state == ST_TA || bit_state == ST_DATA);
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end
        endcase
    end

    // State register with synchronous reset; a reset abandons any frame.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg     <= ST_IDLE;
            div_cnt_reg   <= '0;
            mdc_reg       <= 1'b0;
            bit_cnt_reg   <= 6'd0;
            mdio_o_reg    <= 1'b1;
            mdio_t_reg    <= 1'b1;
            rd_reg        <= 1'b0;
            tx_reg        <= 32'd0;
            shift_reg     <= 16'd0;
            ta_err_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 16'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            mdc_reg       <= mdc_next;
            bit_cnt_reg   <= bit_cnt_next;
            mdio_o_reg    <= mdio_o_next;
            mdio_t_reg    <= mdio_t_next;
            rd_reg        <= rd_next;
            tx_reg        <= tx_next;
            shift_reg     <= shift_next;
            ta_err_reg    <= ta_err_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign busy      = !cmd_ready;
    assign MDC       = mdc_reg;
    assign MDIO_O    = mdio_o_reg;
    assign MDIO_T    = mdio_t_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_mdio_frame_engine.sv
// Bench for mdio_frame_engine: two instances (preamble on / off, CLK_DIV = 4)
// share the command bus; sel picks which one receives commands and is observed.
`timescale 1ns/1ps
module tb_mdio_frame_engine;

    localparam int DIV = 4;

    logic        tb_ACLK = 1'b0;
    logic        areset;
    logic        sel;
    logic        cmd_valid;
    logic        cmd_read;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        mdio_i;

    logic        ready_p, rsp_valid_p, rsp_err_p, busy_p, mdc_p, o_p, t_p;
    logic [15:0] rdata_p;
    logic        ready_n, rsp_valid_n, rsp_err_n, busy_n, mdc_n, o_n, t_n;
    logic [15:0] rdata_n;

    logic        valid_p, valid_n;
    logic        w_ready, w_rsp_valid, w_err, w_busy, w_mdc, w_o, w_t;
    logic [15:0] w_rdata;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_rdata [2];

    assign valid_p     = cmd_valid & ~sel;
    assign valid_n     = cmd_valid & sel;
    assign w_ready     = sel ? ready_n     : ready_p;
    assign w_rsp_valid = sel ? rsp_valid_n : rsp_valid_p;
    assign w_err       = sel ? rsp_err_n   : rsp_err_p;
    assign w_busy      = sel ? busy_n      : busy_p;
    assign w_mdc       = sel ? mdc_n       : mdc_p;
    assign w_o         = sel ? o_n         : o_p;
    assign w_t         = sel ? t_n         : t_p;
    assign w_rdata     = sel ? rdata_n     : rdata_p;

    always #5 tb_ACLK = ~tb_ACLK;

    mdio_frame_engine #(.CLK_DIV(DIV), .PREAMBLE_EN(1'b1)) dut_p (
        .ACLK(tb_ACLK), .ARESET(areset),
        .cmd_valid(valid_p), .cmd_ready(ready_p), .cmd_read(cmd_read),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_p), .rsp_rdata(rdata_p), .rsp_err(rsp_err_p), .busy(busy_p),
        .MDC(mdc_p), .MDIO_O(o_p), .MDIO_T(t_p), .MDIO_I(mdio_i)
    );

    mdio_frame_engine #(.CLK_DIV(DIV), .PREAMBLE_EN(1'b0)) dut_n (
        .ACLK(tb_ACLK), .ARESET(areset),
        .cmd_valid(valid_n), .cmd_ready(ready_n), .cmd_read(cmd_read),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_n), .rsp_rdata(rdata_n), .rsp_err(rsp_err_n), .busy(busy_n),
        .MDC(mdc_n), .MDIO_O(o_n), .MDIO_T(t_n), .MDIO_I(mdio_i)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, expv);
        end
    endtask

    // Full 64-bit frame as the master would send it; read TA/DATA are don't-care.
    function automatic logic [63:0] frame_bits(input logic rd, input logic [4:0] phy,
                                               input logic [4:0] rg, input logic [15:0] wd);
        return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), phy, rg,
                (rd ? 2'b11 : 2'b10), (rd ? 16'h0000 : wd)};
    endfunction

    // What the PHY (or the pull-up) puts on MDIO during frame bit i of n.
    function automatic logic phy_bit(input int i, input int n, input logic on,
                                     input logic ta2, input logic [15:0] d);
        if (i == n - 17) return on ? ta2 : 1'b1;
        if (i >= n - 16 && i < n) return on ? d[15 - (i - (n - 16))] : 1'b1;
        return 1'b1;
    endfunction

    // Issue one command and follow the frame to its response. Returns in the
    // rsp_valid cycle so a following call can be accepted back-to-back.
    task automatic do_frame(input logic rd, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] wd, input logic phy_on, input logic ta2,
                            input logic [15:0] pdata, input logic hold,
                            output logic [15:0] got_rd, output logic got_err, output int waits);
        int n, cyc, rises, cur_bit;
        logic ok_bits, ok_time, ok_ctl, done, prev_mdc, prev_o, prev_t, exp_t;
        logic [63:0] fb;
        n  = sel ? 32 : 64;
        fb = frame_bits(rd, phy, rg, wd);
        cmd_read = rd; cmd_phy_addr = phy; cmd_reg_addr = rg; cmd_wdata = wd;
        cmd_valid = 1'b1;
        mdio_i = 1'b1;
        waits = 0;
        while (!w_ready && waits < 2000) begin
            @(negedge tb_ACLK);
            waits++;
        end
        chk("accept_ready", w_ready, 1);
        @(negedge tb_ACLK);
        cyc = 1;
        if (!hold) cmd_valid = 1'b0;
        cmd_read = 1'($urandom); cmd_phy_addr = 5'($urandom);
        cmd_reg_addr = 5'($urandom); cmd_wdata = 16'($urandom);
        cur_bit = 0;
        mdio_i = phy_bit(0, n, phy_on, ta2, pdata);
        prev_mdc = 1'b0; prev_o = w_o; prev_t = w_t;
        ok_bits = 1'b1; ok_time = 1'b1; ok_ctl = 1'b1; done = 1'b0; rises = 0;
        while (!done && cyc < n * 2 * DIV + 100) begin
            if (w_rsp_valid) begin
                done = 1'b1;
            end else begin
                if (!w_busy || w_ready) ok_ctl = 1'b0;
                if (w_mdc && !prev_mdc) begin
                    if (cyc != 1 + cur_bit * 2 * DIV + DIV) ok_time = 1'b0;
                    exp_t = rd && (cur_bit >= n - 18);
                    if (w_t !== exp_t) ok_bits = 1'b0;
                    if (!exp_t && w_o !== fb[n - 1 - cur_bit]) ok_bits = 1'b0;
                    rises++;
                end
                if (!w_mdc && prev_mdc) begin
                    cur_bit++;
                    mdio_i = phy_bit(cur_bit, n, phy_on, ta2, pdata);
                end else if (cyc > 1 && (w_o !== prev_o || w_t !== prev_t)) begin
                    ok_bits = 1'b0;
                end
                prev_mdc = w_mdc; prev_o = w_o; prev_t = w_t;
                @(negedge tb_ACLK);
                cyc++;
            end
        end
        chk("rsp_valid_seen", done, 1);
        chk("rsp_latency", cyc, n * 2 * DIV + 1);
        chk("frame_bits", ok_bits, 1);
        chk("mdc_timing", ok_time, 1);
        chk("mdc_rises", rises, n);
        chk("busy_in_frame", ok_ctl, 1);
        chk("done_mdc_t_busy_ready", {w_mdc, w_t, w_busy, w_ready}, 4'b0101);
        got_rd  = w_rdata;
        got_err = w_err;
        mdio_i  = 1'b1;
    endtask

    // Reference response: reads return PHY data or all-ones; writes hold rdata.
    task automatic model_rsp(input logic s, input logic rd, input logic phy_on,
                             input logic ta2, input logic [15:0] pdata,
                             output logic [15:0] e_rd, output logic e_err);
        if (rd) begin
            exp_rdata[s] = phy_on ? pdata : 16'hFFFF;
            e_err = phy_on ? ta2 : 1'b1;
        end else begin
            e_err = 1'b0;
        end
        e_rd = exp_rdata[s];
    endtask

    typedef struct {
        logic        s;
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic        phy_on;
        logic        ta2;
        logic [15:0] pdata;
        logic [15:0] e_rd;
        logic        e_err;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [15:0] got_rd, e_rd;
        logic        got_err, e_err;
        int          waits, seen;

        vecs[0] = '{1'b0, 1'b0, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'h1F, 5'h02, 16'h0000, 1'b1, 1'b0, 16'h796D, 16'h796D, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'h1F, 5'h03, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 5'h05, 5'h1A, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 5'h03, 5'h11, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 5'h0F, 5'h1F, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 5'h10, 5'h01, 16'h0000, 1'b1, 1'b1, 16'h8001, 16'h8001, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 5'h1E, 5'h0C, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0};

        areset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0;
        cmd_phy_addr = 5'd0; cmd_reg_addr = 5'd0; cmd_wdata = 16'd0; mdio_i = 1'b1;
        exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
        repeat (3) @(negedge tb_ACLK);
        areset = 1'b0;
        @(negedge tb_ACLK);

        chk("reset_mdc", w_mdc, 0);
        chk("reset_mdio_o", w_o, 1);
        chk("reset_mdio_t", w_t, 1);
        chk("reset_cmd_ready", w_ready, 1);
        chk("reset_busy", w_busy, 0);
        chk("reset_rsp_valid", w_rsp_valid, 0);
        chk("reset_rsp_rdata", w_rdata, 16'h0000);
        chk("reset_rsp_err", w_err, 0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].s;
            @(negedge tb_ACLK);
            chk("rsp_pulse_one_cycle", w_rsp_valid, 0);
            do_frame(vecs[i].rd, vecs[i].phy, vecs[i].rg, vecs[i].wd, vecs[i].phy_on,
                     vecs[i].ta2, vecs[i].pdata, 1'b0, got_rd, got_err, waits);
            model_rsp(vecs[i].s, vecs[i].rd, vecs[i].phy_on, vecs[i].ta2, vecs[i].pdata, e_rd, e_err);
            $display("vec %0d sel=%0d rd=%0d rdata=0x%04h err=%0d", i, vecs[i].s, vecs[i].rd, got_rd, got_err);
            chk("vec_rdata", got_rd, vecs[i].e_rd);
            chk("vec_err", got_err, vecs[i].e_err);
        end

        // Randomized frames against the reference model.
        for (int i = 0; i < 10; i++) begin
            logic rd, on, ta2;
            logic [4:0] phy, rg;
            logic [15:0] wd, pd;
            sel = 1'($urandom); rd = 1'($urandom); on = 1'($urandom); ta2 = 1'($urandom);
            phy = 5'($urandom); rg = 5'($urandom); wd = 16'($urandom); pd = 16'($urandom);
            @(negedge tb_ACLK);
            do_frame(rd, phy, rg, wd, on, ta2, pd, 1'b0, got_rd, got_err, waits);
            model_rsp(sel, rd, on, ta2, pd, e_rd, e_err);
            $display("rnd %0d sel=%0d rd=%0d rdata=0x%04h err=%0d", i, sel, rd, got_rd, got_err);
            chk("rnd_rdata", got_rd, e_rd);
            chk("rnd_err", got_err, e_err);
        end

        // Back-to-back with cmd_valid held high: second command taken in DONE.
        sel = 1'b0;
        @(negedge tb_ACLK);
        do_frame(1'b0, 5'h02, 5'h04, 16'hC0DE, 1'b0, 1'b0, 16'h0000, 1'b1, got_rd, got_err, waits);
        model_rsp(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, e_rd, e_err);
        $display("b2b first rdata=0x%04h err=%0d", got_rd, got_err);
        chk("b2b_first_err", got_err, e_err);
        do_frame(1'b1, 5'h07, 5'h09, 16'h0000, 1'b1, 1'b0, 16'h3C96, 1'b0, got_rd, got_err, waits);
        model_rsp(1'b0, 1'b1, 1'b1, 1'b0, 16'h3C96, e_rd, e_err);
        $display("b2b second rdata=0x%04h err=%0d", got_rd, got_err);
        chk("b2b_accept_wait", waits, 0);
        chk("b2b_second_rdata", got_rd, e_rd);
        chk("b2b_second_err", got_err, e_err);

        // Reset during the DATA phase of a read abandons the frame.
        @(negedge tb_ACLK);
        cmd_read = 1'b1; cmd_phy_addr = 5'h01; cmd_reg_addr = 5'h01; cmd_valid = 1'b1;
        @(negedge tb_ACLK);
        cmd_valid = 1'b0;
        repeat (400) @(negedge tb_ACLK);
        chk("pre_reset_busy", w_busy, 1);
        areset = 1'b1;
        @(negedge tb_ACLK);
        areset = 1'b0;
        exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
        $display("mid-frame reset mdc=%0d t=%0d ready=%0d", w_mdc, w_t, w_ready);
        chk("rst_mdc", w_mdc, 0);
        chk("rst_mdio_t", w_t, 1);
        chk("rst_cmd_ready", w_ready, 1);
        chk("rst_busy", w_busy, 0);
        chk("rst_rsp_valid", w_rsp_valid, 0);
        chk("rst_rdata", w_rdata, 16'h0000);
        seen = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge tb_ACLK);
            if (w_rsp_valid || w_mdc) seen++;
        end
        chk("rst_no_activity", seen, 0);
        do_frame(1'b0, 5'h01, 5'h00, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, got_rd, got_err, waits);
        model_rsp(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, e_rd, e_err);
        $display("post-reset write rdata=0x%04h err=%0d", got_rd, got_err);
        chk("post_rst_rdata", got_rd, e_rd);
        chk("post_rst_err", got_err, e_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdio_frame_engine.md
# mdio_frame_engine

Clause-22 MDIO master frame engine that sits directly downstream of the Serial Management Interface AXI4-Lite register slave. It accepts one management command per handshake from the register block: PHY address, register address, opcode and write data. It serialises the command onto MDC/MDIO, with a tri-state MDIO pad split into O/T/I. It returns read data and a turnaround-error flag to the register block as a one-cycle response pulse.

## Interface
- CLK_DIV, 10: ACLK cycles per MDC half-period, minimum 2. The default gives 2.5 MHz MDC at 50 MHz ACLK.
- PREAMBLE_EN, 1: 1 = send the 32-bit all-ones preamble; 0 = suppress the preamble.

- ACLK  in  1  single clock; all logic on the rising edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, command accepted when valid&ready
- cmd_read  in  1  1 = read (OP=10), 0 = write (OP=01)
- cmd_phy_addr  in  5  PHYAD
- cmd_reg_addr  in  5  REGAD
- cmd_wdata  in  16  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse at frame end
- rsp_rdata  out  16  read data; holds its last value across writes
- rsp_err  out  1  read TA bit 2 sampled as 1 (no PHY); 0 for writes
- busy  out  1  frame in progress
- MDC  out  1  management clock
- MDIO_O  out  1  pad output value
- MDIO_T  out  1  pad tri-state control, 1 = released/input
- MDIO_I  in  1  pad input value

## Operation
- Frame bits, MSB first:
  - preamble, 32×'1', only if PREAMBLE_EN = 1
  - ST = 01
  - OP
  - PHYAD[4:0]
  - REGAD[4:0]
  - TA
  - DATA[15:0]
- Frame length N = 64 bits (PREAMBLE_EN = 1) or 32 bits (PREAMBLE_EN = 0).
- Write frames: TA = "10"; the master drives all bits (MDIO_T = 0 throughout).
- Read frames:
  - The master drives bits up to and including OP/PHYAD/REGAD.
  - MDIO_T = 1 from the first TA bit through the end of DATA.
  - TA bit 2 is sampled; a value of 1 sets rsp_err.
  - DATA is sampled into a shift register, MSB first.
- FSM states:
  - IDLE: cmd_ready = 1; leave on accept.
  - PRE: 32 bits; skipped when PREAMBLE_EN = 0.
  - HDR: 14 bits, ST/OP/PHYAD/REGAD.
  - TA: 2 bits.
  - DATA: 16 bits.
  - DONE: 1 cycle; rsp_valid = 1, then IDLE.
- Command fields are latched on accept. Input changes after accept have no effect.
- Counters:
  - divider counter 0..CLK_DIV-1
  - phase bit, MDC low/high
  - bit counter, 6 bits, wraps per state

## Timing
- Reset values:
  - MDC = 0, MDIO_O = 1, MDIO_T = 1
  - cmd_ready = 1, busy = 0
  - rsp_valid = 0, rsp_rdata = 0x0000, rsp_err = 0
  - FSM = IDLE
- Reset mid-frame: the next edge forces all reset values. The frame is abandoned with no rsp_valid.
- Accept at edge T0 (cmd_valid & cmd_ready):
  - From T0+1: busy = 1, cmd_ready = 0.
  - Bit 0 is driven on MDIO_O/MDIO_T from T0+1.
- Bit period structure:
  - Each bit spans 2×CLK_DIV cycles: MDC low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MDIO_O/MDIO_T change only on the cycle MDC goes low, i.e. the start of the bit. This gives CLK_DIV cycles of setup before the MDC rise.
  - MDIO_I is sampled on the ACLK edge where MDC transitions 0→1.
- Frame end:
  - After the final bit's high phase: MDC = 0 and MDIO_T = 1.
  - DONE asserts rsp_valid at cycle T0 + 1 + N×2×CLK_DIV.
  - rsp_rdata/rsp_err update in that same cycle.
  - busy = 0 and cmd_ready = 1 in that same cycle.
- A command present during DONE/IDLE is accepted immediately: back-to-back frames with zero idle ACLK between DONE and the next bit 0.
- MDC idles low. There is no MDC activity in IDLE.

## Test plan
- Write, CLK_DIV = 4, PREAMBLE_EN = 1, PHY = 0x01, REG = 0x00, data = 0x1140:
  - MDIO sequence, sampled at MDC rises: 32×1, 01, 01, 00001, 00000, 10, 0001000101000000.
  - MDIO_T = 0 throughout.
  - rsp_valid exactly 513 cycles after accept.
  - rsp_err = 0.
- Read, PHY model drives TA2 = 0 and data 0x796D from the falling edges, PHY = 0x1F, REG = 0x02:
  - MDIO_T = 1 for the last 18 bits.
  - rsp_rdata = 0x796D, rsp_err = 0.
- Read with no PHY (MDIO_I held 1) -> rsp_err = 1, rsp_rdata = 0xFFFF.
- PREAMBLE_EN = 0, CLK_DIV = 4, write -> 32-bit frame starting with 01, rsp_valid 257 cycles after accept.
- Back-to-back: cmd_valid held high with two commands -> the second is accepted on the rsp_valid cycle of the first, with no MDC gap beyond the frame boundary.
- ARESET pulsed during DATA of a read -> next cycle MDC = 0, MDIO_T = 1, cmd_ready = 1, no rsp_valid. A subsequent write then completes normally.
